// File: rtl/rdyacpt_pkg.sv
// rtl/rdyacpt_pkg.sv - shared constants and helpers for the rdy/acpt round-robin mux
package rdyacpt_pkg;

  localparam int NCH_MIN = 2;
  localparam int NCH_MAX = 16;

  // Channel tag width; never narrower than one bit so NCH=2 still gets a tag.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rdyacpt_hs_chk.sv
// rtl/rdyacpt_hs_chk.sv - per-port handshake and data-hold checker for one rdy/acpt port
module rdyacpt_hs_chk #(
  parameter int W = 8
) (
  input logic         clk,
  input logic         reset_n,
  input logic         rdy,
  input logic         acpt,
  input logic [W-1:0] data
);

  logic         pend_q;
  logic [W-1:0] data_q;

  // Pending state is cleared by reset so a dropped word never trips the check.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= 1'b0;
      data_q <= '0;
    end else begin
      pend_q <= rdy & ~acpt;
      data_q <= data;
    end
  end

  always @(posedge clk) begin
    if (reset_n && pend_q) begin
      assert (rdy);
      assert (data == data_q);
    end
  end

endmodule

// File: rtl/rdyacpt_rr_arb.sv
// rtl/rdyacpt_rr_arb.sv - combinational round-robin arbiter, search starts at ptr and wraps
module rdyacpt_rr_arb
  import rdyacpt_pkg::*;
#(
  parameter int NCH = 4,
  localparam int IDW = clog2_min1(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [NCH-1:0] gnt,
  output logic [IDW-1:0] gnt_idx,
  output logic           any
);

  int idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int off = 0; off < NCH; off++) begin
      idx = (int'(ptr) + off) % NCH;
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
    // gnt_idx stays valid without en so the mux can still steer data
    if (any && en) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rdyacpt_rr_mux.sv
// rtl/rdyacpt_rr_mux.sv - N-to-1 round-robin rdy/acpt mux with a registered, channel-tagged output slot
module rdyacpt_rr_mux
  import rdyacpt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  localparam int IDW  = clog2_min1(NCH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NCH-1:0]       rdy_di,
  input  logic [NCH*WIDTH-1:0] data_di,
  output logic [NCH-1:0]       acpt_di,
  output logic                 rdy_do,
  output logic [WIDTH-1:0]     data_do,
  output logic [IDW-1:0]       chan_do,
  input  logic                 acpt_do
);

  typedef logic [IDW-1:0] chan_id_t;

  chan_id_t         ptr_q, ptr_d, chan_q, chan_d, gnt_idx;
  logic             rdy_q, rdy_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [NCH-1:0]   gnt;
  logic             any, can_load, load;

  if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_nch_range
    $error("rdyacpt_rr_mux: NCH out of range");
  end

  // reset_n in the enable keeps acpt_di low for the whole reset window
  assign can_load = (~rdy_q | acpt_do) & reset_n;
  assign load     = any & can_load;
  assign acpt_di  = gnt;

  rdyacpt_rr_arb #(.NCH(NCH)) u_arb (
    .req     (rdy_di),
    .ptr     (ptr_q),
    .en      (can_load),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  always_comb begin
    rdy_d  = rdy_q & ~acpt_do;
    data_d = data_q;
    chan_d = chan_q;
    ptr_d  = ptr_q;
    if (load) begin
      rdy_d  = 1'b1;
      data_d = data_di[int'(gnt_idx)*WIDTH +: WIDTH];
      chan_d = gnt_idx;
      ptr_d  = (gnt_idx == chan_id_t'(NCH-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q  <= 1'b0;
      data_q <= '0;
      chan_q <= '0;
      ptr_q  <= '0;
    end else begin
      rdy_q  <= rdy_d;
      data_q <= data_d;
      chan_q <= chan_d;
      ptr_q  <= ptr_d;
    end
  end

  assign rdy_do  = rdy_q;
  assign data_do = data_q;
  assign chan_do = chan_q;

  for (genvar i = 0; i < NCH; i++) begin : g_up_chk
    rdyacpt_hs_chk #(.W(WIDTH)) u_chk (
      .clk     (clk),
      .reset_n (reset_n),
      .rdy     (rdy_di[i]),
      .acpt    (acpt_di[i]),
      .data    (data_di[i*WIDTH +: WIDTH])
    );
  end

  rdyacpt_hs_chk #(.W(WIDTH+IDW)) u_dn_chk (
    .clk     (clk),
    .reset_n (reset_n),
    .rdy     (rdy_do),
    .acpt    (acpt_do),
    .data    ({chan_do, data_do})
  );

endmodule

// File: tb/tb_rdyacpt_rr_mux.sv
// tb/tb_rdyacpt_rr_mux.sv - table-driven bench for rdyacpt_rr_mux
module tb_rdyacpt_rr_mux;

  logic        clk;
  logic        reset_n;
  logic [3:0]  rdy_di;
  logic [31:0] data_di;
  logic [3:0]  acpt_di;
  logic        rdy_do;
  logic [7:0]  data_do;
  logic [1:0]  chan_do;
  logic        acpt_do;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  rdy;
    logic [31:0] data;
    logic        acpt;
    logic [3:0]  e_acpt;
    logic        e_rdy;
    logic [7:0]  e_data;
    logic [1:0]  e_chan;
    logic [1:0]  e_ptr;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] D0 = 32'h1312_1110;
  localparam logic [31:0] DA = 32'h1312_A110;
  localparam logic [31:0] D5 = 32'h135A_1110;
  localparam logic [31:0] D7 = 32'h1312_1177;

  rdyacpt_rr_mux #(.WIDTH(8), .NCH(4)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .rdy_di  (rdy_di),
    .data_di (data_di),
    .acpt_di (acpt_di),
    .rdy_do  (rdy_do),
    .data_do (data_do),
    .chan_do (chan_do),
    .acpt_do (acpt_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic [31:0] d, input logic a,
                     input logic [3:0] ea, input logic er, input logic [7:0] ed,
                     input logic [1:0] ec, input logic [1:0] ep);
    vec_t v;
    v.rdy = r; v.data = d; v.acpt = a;
    v.e_acpt = ea; v.e_rdy = er; v.e_data = ed; v.e_chan = ec; v.e_ptr = ep;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b1; rdy_di = '0; data_di = D0; acpt_do = 1'b0;
    #2 reset_n = 1'b0; rdy_di = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rdy_do",  rdy_do,  0);
    chk("reset data_do", data_do, 0);
    chk("reset chan_do", chan_do, 0);
    chk("reset acpt_di", acpt_di, 0);
    chk("reset ptr",     u_dut.ptr_q, 0);
    @(negedge clk);
    reset_n = 1'b1; rdy_di = '0;

    // single channel ch2
    add(4'b0100, D5, 1, 4'b0100, 0, 8'h00, 0, 0);
    add(4'b0000, D5, 1, 4'b0000, 1, 8'h5A, 2, 3);
    add(4'b1000, D0, 1, 4'b1000, 0, 8'h5A, 2, 3);
    // contention, pointer back at 0
    add(4'b1111, D0, 1, 4'b0001, 1, 8'h13, 3, 0);
    add(4'b1111, D0, 1, 4'b0010, 1, 8'h10, 0, 1);
    add(4'b1111, DA, 1, 4'b0100, 1, 8'h11, 1, 2);
    add(4'b1011, DA, 1, 4'b1000, 1, 8'h12, 2, 3);
    add(4'b1011, DA, 1, 4'b0001, 1, 8'h13, 3, 0);
    add(4'b1011, DA, 1, 4'b0010, 1, 8'h10, 0, 1);
    // backpressure holding ch1 word
    for (int i = 0; i < 5; i++) add(4'b1001, DA, 0, 4'b0000, 1, 8'hA1, 1, 2);
    add(4'b1001, DA, 1, 4'b1000, 1, 8'hA1, 1, 2);
    add(4'b0001, DA, 1, 4'b0001, 1, 8'h13, 3, 0);
    add(4'b0100, DA, 1, 4'b0100, 1, 8'h10, 0, 1);
    // wrap-around from ptr=3
    add(4'b1001, DA, 1, 4'b1000, 1, 8'h12, 2, 3);
    add(4'b0001, DA, 1, 4'b0001, 1, 8'h13, 3, 0);
    add(4'b0000, DA, 1, 4'b0000, 1, 8'h10, 0, 1);
    add(4'b0000, DA, 0, 4'b0000, 0, 8'h10, 0, 1);
    // idle pointer hold
    add(4'b0010, DA, 1, 4'b0010, 0, 8'h10, 0, 1);
    add(4'b0000, DA, 1, 4'b0000, 1, 8'hA1, 1, 2);
    for (int i = 0; i < 9; i++) add(4'b0000, DA, 1'(i % 2), 4'b0000, 0, 8'hA1, 1, 2);
    add(4'b0101, DA, 1, 4'b0100, 0, 8'hA1, 1, 2);
    add(4'b0001, DA, 1, 4'b0001, 1, 8'h12, 2, 3);
    add(4'b0000, DA, 1, 4'b0000, 1, 8'h10, 0, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      rdy_di = vecs[i].rdy; data_di = vecs[i].data; acpt_do = vecs[i].acpt;
      #1;
      chk($sformatf("v%0d acpt_di", i), acpt_di, vecs[i].e_acpt);
      chk($sformatf("v%0d rdy_do",  i), rdy_do,  vecs[i].e_rdy);
      chk($sformatf("v%0d data_do", i), data_do, vecs[i].e_data);
      chk($sformatf("v%0d chan_do", i), chan_do, vecs[i].e_chan);
      chk($sformatf("v%0d ptr",     i), u_dut.ptr_q, vecs[i].e_ptr);
    end

    // reset while a word is held under backpressure
    @(negedge clk);
    rdy_di = 4'b0001; data_di = D7; acpt_do = 1'b1;
    #1 chk("mid load acpt_di", acpt_di, 4'b0001);
    @(negedge clk);
    rdy_di = 4'b0000; acpt_do = 1'b0;
    #1;
    chk("mid held rdy_do",  rdy_do,  1);
    chk("mid held data_do", data_do, 8'h77);
    #2 reset_n = 1'b0; rdy_di = 4'b1011;
    #1;
    chk("mid rst rdy_do",  rdy_do,  0);
    chk("mid rst data_do", data_do, 0);
    chk("mid rst chan_do", chan_do, 0);
    chk("mid rst acpt_di", acpt_di, 0);
    @(posedge clk);
    #1;
    chk("mid rst edge acpt_di", acpt_di, 0);
    chk("mid rst ptr", u_dut.ptr_q, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("post rst acpt_di", acpt_di, 4'b0001);
    @(posedge clk);
    #1;
    chk("post rst rdy_do",  rdy_do,  1);
    chk("post rst data_do", data_do, 8'h77);
    chk("post rst chan_do", chan_do, 0);
    chk("post rst ptr",     u_dut.ptr_q, 1);
    @(negedge clk);
    rdy_di = 4'b1010; acpt_do = 1'b1;
    #1 chk("drain1 acpt_di", acpt_di, 4'b0010);
    @(negedge clk);
    rdy_di = 4'b1000;
    #1;
    chk("drain2 acpt_di", acpt_di, 4'b1000);
    chk("drain2 chan_do", chan_do, 1);
    @(negedge clk);
    rdy_di = 4'b0000;
    #1;
    chk("drain3 chan_do", chan_do, 3);
    chk("drain3 data_do", data_do, 8'h13);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
